// File: rtl/load_store_align_unit_pkg.sv
// Shared definitions for the load/store alignment unit: funct3 codes, FSM encoding, size masks.
// Also holds the funct3 legality check so the top and any future users agree on it.
package load_store_align_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CMD2  = 3'd3,
        ST_WAIT2 = 3'd4,
        ST_RSP   = 3'd5
    } state_t;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3, input int xlen);
        if (we)
            return !((f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW) ||
                     ((f3 == F3_SD) && (xlen == 64)));
        if (f3 == 3'b111)
            return 1'b1;
        if ((xlen == 32) && ((f3 == F3_LD) || (f3 == F3_LWU)))
            return 1'b1;
        return 1'b0;
    endfunction

endpackage

// File: rtl/load_store_align_unit_load_extend.sv
// Combinational lane shift and sign/zero extension of load data; zero latency.
// No handshake: result follows data/offset/funct3 directly.
module load_extend
    import load_store_align_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]             data,
    input  logic [$clog2(XLEN/8)-1:0]   offset,
    input  logic [2:0]                  funct3,
    output logic [XLEN-1:0]             result
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = data >> {offset, 3'b000};
        result  = shifted;
        case (funct3)
            F3_LB:   result = XLEN'(signed'(shifted[7:0]));
            F3_LH:   result = XLEN'(signed'(shifted[15:0]));
            F3_LW:   result = XLEN'(signed'(shifted[31:0]));
            F3_LBU:  result = XLEN'(shifted[7:0]);
            F3_LHU:  result = XLEN'(shifted[15:0]);
            F3_LWU:  result = XLEN'(shifted[31:0]);
            F3_LD:   result = shifted;
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_align_unit.sv
// MEM-stage load/store aligner: single outstanding access, load rsp >= 3 cycles, store >= 2, error 1.
// req_ready only in IDLE; mem_valid held stable until mem_ready. MISALIGNED_SPLIT_EN enables two-beat misaligned accesses.
module load_store_align_unit
    import load_store_align_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_data,
    output logic                rsp_err
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    state_t              state, state_nxt;
    logic                we_q;
    logic [2:0]          f3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [XLEN-1:0]     wdata_q;
    logic [XLEN-1:0]     rsp_data_q;
    logic                rsp_err_q;

    logic                accept;
    logic [OFF_W-1:0]    req_off, off_q;
    logic [3:0]          req_bytes;
    logic                req_illegal, req_misal, req_err, req_split, split_q;
    logic [ADDR_W-1:0]   base_addr;
    logic [NB-1:0]       be_lo, be_hi;
    logic [XLEN-1:0]     wd_lo, wd_hi;
    logic [XLEN-1:0]     ext_data, ext_result;
    logic [OFF_W-1:0]    ext_off;

    assign accept      = req_valid && (state == ST_IDLE);
    assign req_off     = req_addr[OFF_W-1:0];
    assign req_bytes   = 4'd1 << req_funct3[1:0];
    assign req_illegal = funct3_illegal(req_we, req_funct3, XLEN);
    assign req_misal   = (req_off & OFF_W'(req_bytes - 4'd1)) != '0;
    assign off_q       = addr_q[OFF_W-1:0];
    assign base_addr   = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};

`ifdef MISALIGNED_SPLIT_EN
    logic [2*NB-1:0]   be_wide;
    logic [2*XLEN-1:0] wd_wide;
    logic [2*XLEN-1:0] merged;
    logic [XLEN-1:0]   beat1_q;

    // Only accesses spilling past the word end need a second beat.
    assign req_split = req_misal && ((int'(req_off) + int'(req_bytes)) > NB);
    assign req_err   = req_illegal;
    assign be_wide   = (2*NB)'(size_mask(f3_q[1:0])) << off_q;
    assign wd_wide   = (2*XLEN)'(wdata_q) << {off_q, 3'b000};
    assign be_lo     = be_wide[NB-1:0];
    assign be_hi     = be_wide[2*NB-1:NB];
    assign wd_lo     = wd_wide[XLEN-1:0];
    assign wd_hi     = wd_wide[2*XLEN-1:XLEN];
    assign merged    = {mem_rdata, beat1_q} >> {off_q, 3'b000};
    assign ext_data  = (state == ST_WAIT2) ? merged[XLEN-1:0] : mem_rdata;
    assign ext_off   = (state == ST_WAIT2) ? '0 : off_q;
`else
    assign req_split = 1'b0;
    assign req_err   = req_illegal || req_misal;
    assign be_lo     = NB'(size_mask(f3_q[1:0])) << off_q;
    assign be_hi     = '0;
    assign wd_lo     = wdata_q << {off_q, 3'b000};
    assign wd_hi     = '0;
    assign ext_data  = mem_rdata;
    assign ext_off   = off_q;
`endif

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .data   (ext_data),
        .offset (ext_off),
        .funct3 (f3_q),
        .result (ext_result)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req_valid) state_nxt = req_err ? ST_RSP : ST_CMD;
            ST_CMD:   if (mem_ready) state_nxt = !we_q ? ST_WAIT : (split_q ? ST_CMD2 : ST_RSP);
            ST_WAIT:  if (mem_rvalid) state_nxt = split_q ? ST_CMD2 : ST_RSP;
`ifdef MISALIGNED_SPLIT_EN
            ST_CMD2:  if (mem_ready) state_nxt = we_q ? ST_RSP : ST_WAIT2;
            ST_WAIT2: if (mem_rvalid) state_nxt = ST_RSP;
`endif
            ST_RSP:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Memory command is decoded from latched request state only, so it cannot glitch with req_*.
    always_comb begin
        req_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RSP);
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        if (state == ST_CMD) begin
            mem_valid = 1'b1;
            mem_we    = we_q;
            mem_addr  = base_addr;
            mem_be    = be_lo;
            mem_wdata = wd_lo;
        end else if (state == ST_CMD2) begin
            mem_valid = 1'b1;
            mem_we    = we_q;
            mem_addr  = base_addr + ADDR_W'(NB);
            mem_be    = be_hi;
            mem_wdata = wd_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            split_q    <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            if (accept) begin
                we_q      <= req_we;
                f3_q      <= req_funct3;
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                split_q   <= req_split;
                rsp_err_q <= req_err;
            end
            if (((state == ST_WAIT) || (state == ST_WAIT2)) && (state_nxt == ST_RSP))
                rsp_data_q <= ext_result;
        end
    end

`ifdef MISALIGNED_SPLIT_EN
    always_ff @(posedge clk) begin
        if (rst)
            beat1_q <= '0;
        else if ((state == ST_WAIT) && mem_rvalid)
            beat1_q <= mem_rdata;
    end
`endif

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_load_store_align_unit.sv
// Directed self-checking bench for load_store_align_unit at XLEN=32 and XLEN=64.
module tb_load_store_align_unit;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;

    logic        req_valid64, req_ready64, req_we64;
    logic [2:0]  req_funct3_64;
    logic [31:0] req_addr64;
    logic [63:0] req_wdata64;
    logic        mem_valid64, mem_ready64, mem_we64, mem_rvalid64;
    logic [31:0] mem_addr64;
    logic [63:0] mem_wdata64, mem_rdata64;
    logic [7:0]  mem_be64;
    logic        rsp_valid64, rsp_err64;
    logic [63:0] rsp_data64;

    load_store_align_unit #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    load_store_align_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid64), .req_ready(req_ready64), .req_we(req_we64),
        .req_funct3(req_funct3_64), .req_addr(req_addr64), .req_wdata(req_wdata64),
        .mem_valid(mem_valid64), .mem_ready(mem_ready64), .mem_addr(mem_addr64),
        .mem_we(mem_we64), .mem_be(mem_be64), .mem_wdata(mem_wdata64),
        .mem_rvalid(mem_rvalid64), .mem_rdata(mem_rdata64),
        .rsp_valid(rsp_valid64), .rsp_data(rsp_data64), .rsp_err(rsp_err64)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic issue64(input logic [2:0] f3, input logic [31:0] addr);
        req_valid64   = 1'b1;
        req_we64      = 1'b0;
        req_funct3_64 = f3;
        req_addr64    = addr;
        req_wdata64   = '0;
        tick();
        req_valid64   = 1'b0;
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        req_valid64 = 1'b0; req_we64 = 1'b0; req_funct3_64 = '0; req_addr64 = '0; req_wdata64 = '0;
        mem_ready64 = 1'b1; mem_rvalid64 = 1'b0; mem_rdata64 = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_we",    mem_we, 0);
        chk("rst_mem_be",    mem_be, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_addr",  mem_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data",  rsp_data, 0);
        chk("rst_rsp_err",   rsp_err, 0);

        // LB at 0x1003
        issue(1'b0, 3'b000, 32'h1003, 32'h0);
        chk("lb_c1_mem_valid", mem_valid, 1);
        chk("lb_c1_mem_addr",  mem_addr, 32'h1000);
        chk("lb_c1_mem_be",    mem_be, 4'b1000);
        chk("lb_c1_mem_we",    mem_we, 0);
        chk("lb_c1_req_ready", req_ready, 0);
        tick();
        chk("lb_c2_mem_valid", mem_valid, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
        tick();
        mem_rvalid = 1'b0;
        chk("lb_c3_rsp_valid", rsp_valid, 1);
        chk("lb_c3_rsp_data",  rsp_data, 32'hFFFF_FF80);
        chk("lb_c3_rsp_err",   rsp_err, 0);
        tick();
        chk("lb_c4_rsp_valid", rsp_valid, 0);
        chk("lb_c4_req_ready", req_ready, 1);

        // LHU at 0x2002
        issue(1'b0, 3'b101, 32'h2002, 32'h0);
        chk("lhu_mem_be", mem_be, 4'b1100);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h8001_1234;
        tick();
        mem_rvalid = 1'b0;
        chk("lhu_rsp_valid", rsp_valid, 1);
        chk("lhu_rsp_data",  rsp_data, 32'h0000_8001);
        tick();

        // SH 0xABCD at 0x2002
        issue(1'b1, 3'b001, 32'h2002, 32'h0000_ABCD);
        chk("sh_mem_be",    mem_be, 4'b1100);
        chk("sh_mem_wdata", mem_wdata, 32'hABCD_0000);
        chk("sh_mem_we",    mem_we, 1);
        tick();
        chk("sh_c2_rsp_valid", rsp_valid, 1);
        chk("sh_c2_rsp_data",  rsp_data, 0);
        tick();

        // SB 0x5A at 0x6003
        issue(1'b1, 3'b000, 32'h6003, 32'h0000_005A);
        chk("sb_mem_be",    mem_be, 4'b1000);
        chk("sb_mem_wdata", mem_wdata, 32'h5A00_0000);
        tick();
        tick();

`ifdef MISALIGNED_SPLIT_EN
        // LW at 0x3001 split over two beats
        issue(1'b0, 3'b010, 32'h3001, 32'h0);
        chk("split_b1_addr", mem_addr, 32'h3000);
        chk("split_b1_be",   mem_be, 4'b1110);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h4433_2211;
        tick();
        mem_rvalid = 1'b0;
        chk("split_b2_valid", mem_valid, 1);
        chk("split_b2_addr",  mem_addr, 32'h3004);
        chk("split_b2_be",    mem_be, 4'b0001);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h8877_6655;
        tick();
        mem_rvalid = 1'b0;
        chk("split_rsp_valid", rsp_valid, 1);
        chk("split_rsp_data",  rsp_data, 32'h5544_3322);
        chk("split_rsp_err",   rsp_err, 0);
        tick();
`else
        // LW at 0x3001 is an error with no memory command
        issue(1'b0, 3'b010, 32'h3001, 32'h0);
        chk("mis_c1_rsp_valid", rsp_valid, 1);
        chk("mis_c1_rsp_err",   rsp_err, 1);
        chk("mis_c1_rsp_data",  rsp_data, 0);
        chk("mis_c1_mem_valid", mem_valid, 0);
        tick();
        chk("mis_c2_mem_valid", mem_valid, 0);
        chk("mis_c2_req_ready", req_ready, 1);
`endif

        // Illegal funct3 codes at XLEN=32
        issue(1'b0, 3'b111, 32'h0, 32'h0);
        chk("f3_111_err", rsp_err, 1);
        tick();
        issue(1'b0, 3'b011, 32'h0, 32'h0);
        chk("ld32_err", rsp_err, 1);
        chk("ld32_mem_valid", mem_valid, 0);
        tick();
        issue(1'b1, 3'b100, 32'h0, 32'h0);
        chk("st_100_err", rsp_err, 1);
        tick();

        // SW with mem_ready low for 4 cycles
        mem_ready = 1'b0;
        issue(1'b1, 3'b010, 32'h4000, 32'h1234_5678);
        cyc = 1;
        for (int i = 0; i < 4; i++) begin
            chk("stall_mem_valid", mem_valid, 1);
            chk("stall_mem_addr",  mem_addr, 32'h4000);
            chk("stall_mem_wdata", mem_wdata, 32'h1234_5678);
            tick();
            cyc++;
        end
        mem_ready = 1'b1;
        chk("stall_c5_mem_be", mem_be, 4'b1111);
        while (!rsp_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("stall_rsp_valid", rsp_valid, 1);
        chk("stall_rsp_cycle", cyc, 6);
        tick();

        // Reset while in WAIT drops the late response
        issue(1'b0, 3'b010, 32'h5000, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        chk("rstw_req_ready", req_ready, 1);
        tick();
        mem_rvalid = 1'b0;
        chk("rstw_rsp_valid_a", rsp_valid, 0);
        tick();
        chk("rstw_rsp_valid_b", rsp_valid, 0);

        // mem_rvalid during CMD is ignored
        issue(1'b0, 3'b100, 32'h7001, 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_AA00;
        tick();
        mem_rvalid = 1'b0;
        tick();
        chk("early_rv_rsp_valid", rsp_valid, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_5500;
        tick();
        mem_rvalid = 1'b0;
        chk("early_rv_rsp_valid2", rsp_valid, 1);
        chk("early_rv_rsp_data",   rsp_data, 32'h0000_0055);
        tick();

        // XLEN=64 instance
        issue64(3'b011, 32'h10);
        chk("ld64_mem_be",   mem_be64, 8'hFF);
        chk("ld64_mem_addr", mem_addr64, 32'h10);
        tick();
        mem_rvalid64 = 1'b1; mem_rdata64 = 64'h8000_0000_0000_0001;
        tick();
        mem_rvalid64 = 1'b0;
        chk("ld64_rsp_valid", rsp_valid64, 1);
        chk("ld64_rsp_data",  rsp_data64, 64'h8000_0000_0000_0001);
        chk("ld64_rsp_err",   rsp_err64, 0);
        tick();

        issue64(3'b110, 32'h14);
        chk("lwu64_mem_be",   mem_be64, 8'hF0);
        chk("lwu64_mem_addr", mem_addr64, 32'h10);
        tick();
        mem_rvalid64 = 1'b1; mem_rdata64 = 64'h8000_0000_0000_0001;
        tick();
        mem_rvalid64 = 1'b0;
        chk("lwu64_rsp_data", rsp_data64, 64'h0000_0000_8000_0000);
        tick();

        issue64(3'b010, 32'h14);
        tick();
        mem_rvalid64 = 1'b1; mem_rdata64 = 64'h8000_0000_0000_0001;
        tick();
        mem_rvalid64 = 1'b0;
        chk("lw64_rsp_data", rsp_data64, 64'hFFFF_FFFF_8000_0000);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
